// File: rtl/l1_rd_sched_if.sv
// Bundle of requester-side and read-port-side handshake signals for l1_rd_sched.
// slave is the scheduler's view; master is the AFU/read-port environment view.
interface l1_rd_sched_if #(
  parameter int nreq         = 8,
  parameter int nreq_width   = (nreq > 1) ? $clog2(nreq) : 1,
  parameter int nports       = 8,
  parameter int nstrms       = 64,
  parameter int nstrms_width = (nstrms > 1) ? $clog2(nstrms) : 1
);
  logic [nreq-1:0]                i_req_v;
  logic [nreq-1:0]                i_req_r;
  logic [nreq*nstrms_width-1:0]   i_req_sid;
  logic [nstrms-1:0]              i_l1_end;
  logic [nports-1:0]              o_port_v;
  logic [nports-1:0]              o_port_r;
  logic [nports*nstrms_width-1:0] o_port_sid;
  logic [nports*nreq_width-1:0]   o_port_rid;
  logic [nreq-1:0]                o_discard;

  modport slave (
    input  i_req_v, i_req_sid, i_l1_end, o_port_r,
    output i_req_r, o_port_v, o_port_sid, o_port_rid, o_discard
  );

  modport master (
    output i_req_v, i_req_sid, i_l1_end, o_port_r,
    input  i_req_r, o_port_v, o_port_sid, o_port_rid, o_discard
  );
endinterface

// File: rtl/l1_rd_sched.sv
// Round-robin packer of AFU stream read requests onto L1 read ports, registered as an
// all-or-nothing batch. Optional end-of-stream discard: define L1_RD_SCHED_DISCARD_EN.
module l1_rd_sched #(
  parameter int nreq         = 8,
  parameter int nreq_width   = (nreq > 1) ? $clog2(nreq) : 1,
  parameter int nports       = 8,
  parameter int nstrms       = 64,
  parameter int nstrms_width = (nstrms > 1) ? $clog2(nstrms) : 1
) (
  input  logic           clk,
  input  logic           reset,
  l1_rd_sched_if.slave   bus
);

  localparam int cnt_width = $clog2(nports + 1);

  logic [nstrms_width-1:0] req_sid [nreq];
  logic [nreq-1:0]         disc;

  always_comb begin
    for (int k = 0; k < nreq; k++) req_sid[k] = bus.i_req_sid[k*nstrms_width +: nstrms_width];
  end

`ifdef L1_RD_SCHED_DISCARD_EN
  always_comb begin
    for (int k = 0; k < nreq; k++) disc[k] = bus.i_req_v[k] & bus.i_l1_end[req_sid[k]];
  end
`else
  logic unused_l1_end;
  assign unused_l1_end = ^bus.i_l1_end;
  assign disc          = '0;
`endif

  // Batch register and round-robin pointer
  logic [nports-1:0]       port_v;
  logic [nstrms_width-1:0] port_sid [nports];
  logic [nreq_width-1:0]   port_rid [nports];
  logic [nreq_width-1:0]   rr;

  // Grant scan results
  logic [nreq-1:0]         grant;
  logic [cnt_width-1:0]    cnt;
  logic [nreq_width-1:0]   idx;
  logic [nreq_width-1:0]   last;
  logic                    any;
  logic [nports-1:0]       pick_v;
  logic [nstrms_width-1:0] pick_sid [nports];
  logic [nreq_width-1:0]   pick_rid [nports];
  logic                    load;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    grant  = '0;
    cnt    = '0;
    idx    = '0;
    last   = rr;
    any    = 1'b0;
    pick_v = '0;
    for (int j = 0; j < nports; j++) begin
      pick_sid[j] = '0;
      pick_rid[j] = '0;
    end
    // Scan rr, rr+1, ... with wrap; the j-th grant lands on port j so packing is contiguous.
    for (int i = 0; i < nreq; i++) begin
      idx = nreq_width'((int'(rr) + i) % nreq);
      if (bus.i_req_v[idx] && !disc[idx] && (cnt < cnt_width'(nports))) begin
        grant[idx] = 1'b1;
        last       = idx;
        any        = 1'b1;
        for (int j = 0; j < nports; j++) begin
          if (cnt == cnt_width'(j)) begin
            pick_v[j]   = 1'b1;
            pick_sid[j] = req_sid[idx];
            pick_rid[j] = idx;
          end
        end
        cnt = cnt + cnt_width'(1);
      end
    end
  end

  // The batch advances only as a whole: every valid port must be ready.
  assign load          = ~|port_v | &(~port_v | bus.o_port_r);
  assign bus.i_req_r   = (load & reset) ? (grant | disc) : '0;
  assign bus.o_discard = (load & reset) ? disc : '0;
  assign bus.o_port_v  = port_v;

  for (genvar j = 0; j < nports; j++) begin : g_out
    assign bus.o_port_sid[j*nstrms_width +: nstrms_width] = port_sid[j];
    assign bus.o_port_rid[j*nreq_width +: nreq_width]     = port_rid[j];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample
  // their inputs from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      port_v <= '0;
      rr     <= '0;
      for (int j = 0; j < nports; j++) begin
        port_sid[j] <= '0;
        port_rid[j] <= '0;
      end
    end else if (load) begin
      port_v <= pick_v;
      for (int j = 0; j < nports; j++) begin
        port_sid[j] <= pick_sid[j];
        port_rid[j] <= pick_rid[j];
      end
      if (any) rr <= nreq_width'((int'(last) + 1) % nreq);
    end
  end

endmodule

// File: tb/tb_l1_rd_sched.sv
// Directed bench for l1_rd_sched with nreq=4, nports=2, nstrms=64 (sid 6 bits, rid 2 bits).
// Inputs are driven and outputs sampled just after the falling edge.
module tb_l1_rd_sched;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  l1_rd_sched_if #(.nreq(4), .nports(2), .nstrms(64)) bus ();

  l1_rd_sched #(.nreq(4), .nports(2), .nstrms(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] sids4(input int a, input int b, input int c, input int d);
    return {6'(d), 6'(c), 6'(b), 6'(a)};
  endfunction

  task automatic drive(input logic [3:0] v, input logic [23:0] sid, input logic [1:0] r);
    bus.i_req_v   = v;
    bus.i_req_sid = sid;
    bus.o_port_r  = r;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_batch(input string tag, input logic [1:0] v,
                             input logic [11:0] sid, input logic [3:0] rid);
    check({tag, "_v"}, 64'(bus.o_port_v), 64'(v));
    check({tag, "_sid"}, 64'(bus.o_port_sid), 64'(sid));
    check({tag, "_rid"}, 64'(bus.o_port_rid), 64'(rid));
  endtask

  initial begin
    reset        = 1'b0;
    bus.i_l1_end = '0;
    drive(4'h0, '0, 2'b00);
    repeat (2) next_cycle();

    // Reset state, and requests are refused while reset is low.
    check_batch("rst", 2'b00, 12'h000, 4'h0);
    drive(4'hF, sids4(5, 6, 7, 8), 2'b11);
    check("rst_req_r", 64'(bus.i_req_r), 64'h0);
    check("rst_discard", 64'(bus.o_discard), 64'h0);
    next_cycle();

    // Streaming from an empty batch: req0/1 then req2/3 with no bubble.
    reset = 1'b1;
    drive(4'hF, sids4(5, 6, 7, 8), 2'b11);
    check("s1_req_r", 64'(bus.i_req_r), 64'b0011);
    next_cycle();
    drive(4'b1100, sids4(5, 6, 7, 8), 2'b11);
    check_batch("s2", 2'b11, {6'd6, 6'd5}, {2'd1, 2'd0});
    check("s2_req_r", 64'(bus.i_req_r), 64'b1100);
    next_cycle();
    drive(4'h0, '0, 2'b11);
    check_batch("s3", 2'b11, {6'd8, 6'd7}, {2'd3, 2'd2});
    check("s3_req_r", 64'(bus.i_req_r), 64'h0);
    next_cycle();
    check_batch("s4_empty", 2'b00, 12'h000, 4'h0);

    // Backpressure: port1 not ready for 3 cycles (rr=0).
    drive(4'b0011, sids4(5, 6, 0, 0), 2'b11);
    check("bp_load_req_r", 64'(bus.i_req_r), 64'b0011);
    next_cycle();
    for (int c = 0; c < 3; c++) begin
      drive(4'b1100, sids4(0, 0, 7, 8), 2'b01);
      check_batch($sformatf("bp_hold%0d", c), 2'b11, {6'd6, 6'd5}, {2'd1, 2'd0});
      check($sformatf("bp_req_r%0d", c), 64'(bus.i_req_r), 64'h0);
      next_cycle();
    end
    drive(4'b1100, sids4(0, 0, 7, 8), 2'b11);
    check_batch("bp_release", 2'b11, {6'd6, 6'd5}, {2'd1, 2'd0});
    check("bp_release_req_r", 64'(bus.i_req_r), 64'b1100);
    next_cycle();
    drive(4'h0, '0, 2'b11);
    check_batch("bp_next", 2'b11, {6'd8, 6'd7}, {2'd3, 2'd2});
    next_cycle();

    // Partial grant: only req2 valid (rr 0 -> 3).
    drive(4'b0100, sids4(0, 0, 9, 0), 2'b11);
    check("part_req_r", 64'(bus.i_req_r), 64'b0100);
    next_cycle();
    // Round-robin wrap from rr=3: req3 then req0 (rr -> 1).
    drive(4'b1001, sids4(10, 0, 0, 11), 2'b11);
    check_batch("part", 2'b01, {6'd0, 6'd9}, {2'd0, 2'd2});
    check("wrap_req_r", 64'(bus.i_req_r), 64'b1001);
    next_cycle();
    drive(4'h0, '0, 2'b11);
    check_batch("wrap", 2'b11, {6'd10, 6'd11}, {2'd0, 2'd3});
    next_cycle();
    // Empty grant leaves rr at 1: all valid now grants req1/req2.
    check_batch("none", 2'b00, 12'h000, 4'h0);
    drive(4'hF, sids4(1, 2, 3, 4), 2'b11);
    check("rr_hold_req_r", 64'(bus.i_req_r), 64'b0110);
    next_cycle();
    drive(4'b1001, sids4(1, 2, 3, 4), 2'b11);
    check_batch("rr_hold", 2'b11, {6'd3, 6'd2}, {2'd2, 2'd1});
    check("rr3_req_r", 64'(bus.i_req_r), 64'b1001);
    next_cycle();

    // Reset with a batch pending (rr=1 before reset).
    drive(4'hF, sids4(5, 6, 7, 8), 2'b11);
    check_batch("pre_rst", 2'b11, {6'd1, 6'd4}, {2'd0, 2'd3});
    reset = 1'b0;
    #1;
    check("mid_rst_req_r", 64'(bus.i_req_r), 64'h0);
    next_cycle();
    check_batch("post_rst", 2'b00, 12'h000, 4'h0);
    check("post_rst_req_r", 64'(bus.i_req_r), 64'h0);
    reset = 1'b1;
    #1;
    check("rst_rr_req_r", 64'(bus.i_req_r), 64'b0011);
    next_cycle();
    drive(4'b1100, sids4(5, 6, 7, 8), 2'b11);
    check_batch("rst_rr", 2'b11, {6'd6, 6'd5}, {2'd1, 2'd0});
    next_cycle();

    // End-of-stream flag on sid 6 with requesters on sids 5, 6, 7 (rr=0).
    bus.i_l1_end = 64'd1 << 6;
    drive(4'b0111, sids4(5, 6, 7, 0), 2'b11);
`ifdef L1_RD_SCHED_DISCARD_EN
    check("disc_req_r", 64'(bus.i_req_r), 64'b0111);
    check("disc_pulse", 64'(bus.o_discard), 64'b0010);
    next_cycle();
    drive(4'h0, '0, 2'b11);
    check_batch("disc", 2'b11, {6'd7, 6'd5}, {2'd2, 2'd0});
`else
    check("disc_req_r", 64'(bus.i_req_r), 64'b0011);
    check("disc_pulse", 64'(bus.o_discard), 64'h0);
    next_cycle();
    drive(4'h0, '0, 2'b11);
    check_batch("disc", 2'b11, {6'd6, 6'd5}, {2'd1, 2'd0});
`endif
    bus.i_l1_end = '0;
    next_cycle();
    check_batch("final_empty", 2'b00, 12'h000, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l1_rd_sched.md
# l1_rd_sched

Read-request scheduler in front of the L1 read ports. Collects stream read requests from `nreq` independent AFU requesters and packs up to `nports` of them per cycle onto the read ports. Packing is contiguous and starts at port 0, so lower-numbered ports always hold earlier requests; the per-port pointer-increment logic depends on this. Arbitration is round-robin for fairness, and the output is registered as an all-or-nothing batch so read ports always advance together.

## Interface
Parameters:
- `nreq`, 8, number of AFU requesters.
- `nreq_width`, `$clog2(nreq)`, requester id width (minimum 1).
- `nports`, 8, number of L1 read ports.
- `nstrms`, 64, number of streams.
- `nstrms_width`, `$clog2(nstrms)`, stream id width.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `i_req_v`  in  nreq  per-requester request valid.
- `i_req_r`  out  nreq  per-requester request ready (accept).
- `i_req_sid`  in  nreq*nstrms_width  per-requester stream id; requester k occupies slice k.
- `i_l1_end`  in  nstrms  L1 end-of-stream flags; used only when discard is compiled in.
- `o_port_v`  out  nports  per-port valid of the current batch.
- `o_port_r`  in  nports  per-port ready from the read port.
- `o_port_sid`  out  nports*nstrms_width  stream id per port.
- `o_port_rid`  out  nports*nreq_width  originating requester id per port, used to route returned data.
- `o_discard`  out  nreq  per-requester discard pulse; tied to 0 when discard is compiled out.

## Operation
- **Batch register.** Holds `o_port_v`, `o_port_sid` and `o_port_rid`.
- **Drain.** `drain = ~|o_port_v | &(~o_port_v | o_port_r)`. The batch drains only when every valid port is ready.
- **Load.** `load = drain`. While `load` is low, all `i_req_r` bits are 0 and the rr pointer holds.
- **Grant.**
  - Scan requesters starting at `rr` and moving upward with wrap (`rr`, `rr+1`, … `rr+nreq-1` mod nreq).
  - Eligible requesters are those with `i_req_v` high.
  - The first `min(nports, #eligible)` in scan order are granted.
  - The j-th grant in scan order goes to port j.
- **Accept.** `i_req_r[k] = load & grant[k]`. `i_req_r` must not depend on `o_port_r` except through `load`.
- **Batch fill on load.**
  - `o_port_v[j]` is 1 for j < #grants and 0 otherwise. Valid ports are always contiguous from port 0.
  - `o_port_sid[j]` and `o_port_rid[j]` come from the j-th granted requester.
  - Sid and rid slices of invalid ports are 0.
- **rr update on load.**
  - If at least one requester was granted: `rr` = (index of last granted requester + 1) mod nreq.
  - If nothing was granted: `rr` is unchanged and the batch becomes empty.
- **Arithmetic.** Grant counting saturates at `nports`. All index arithmetic is mod nreq with width `nreq_width`.
- **Simultaneous events.** A batch draining and a new batch loading in the same cycle is the normal streaming case and inserts no bubble.
- **Reset (reset==0 on an edge):**
  - `o_port_v` = 0, sids = 0, rids = 0, `rr` = 0.
  - `i_req_r` is forced to 0 and `o_discard` to 0 while reset is low.
  - Reset mid-batch drops the batch; no handshake completes.

## Timing
- **Latency.** A request accepted at edge t is presented on `o_port_v` in cycle t+1, where cycle t+1 is the cycle after edge t.
- **Throughput.** Up to `nports` requests per cycle when all ports are ready every cycle.
- **Backpressure.** With any valid port not ready, the batch holds stable (v, sid and rid unchanged) and no new requests are accepted.
- **Requester side.** Standard valid/ready. A requester must hold `i_req_v` and `i_req_sid` until `i_req_r` is seen high. A request seen with `i_req_r` low is not consumed.
- **Combinational path.** `i_req_r` depends on `o_port_v`, `o_port_r` and `i_req_v` within the same cycle. No combinational path exists from `i_req_sid` to `i_req_r` unless discard is enabled.

## Configuration
- **Macro.** `L1_RD_SCHED_DISCARD_EN`.
- **Defined.**
  - A requester whose `i_l1_end[sid]` is high is treated as discardable.
  - On `load`, every discardable valid requester is accepted (`i_req_r=1`) and `o_discard[k]=1` is asserted in the same cycle.
  - A discarded request occupies no port and does not count toward `nports`.
  - Discarded requesters do not influence the rr update.
- **Undefined.** `i_l1_end` is ignored and `o_discard` is constant 0. Ended-stream requests are scheduled normally, and the read port invalidates them downstream.

## Test plan
- **Empty batch.** Reset, then nreq=4, nports=2 with all requesters valid, sids 5, 6, 7, 8, and all ports ready.
  - Edge 1: accepts req0 and req1.
  - Cycle 2: port0 sid 5 / rid 0, port1 sid 6 / rid 1; req2 and req3 are accepted at edge 2.
  - Cycle 3: port0 sid 7, port1 sid 8.
- **Backpressure.** Batch {sid 5, sid 6} with `o_port_r`=2'b01 for 3 cycles.
  - Batch stays stable and `i_req_r`=0 for those 3 cycles.
  - The cycle `o_port_r` becomes 2'b11, the next batch loads.
- **Round-robin wrap.** nreq=4, nports=2, rr=3, requesters 0 and 3 valid.
  - Grants: port0 = rid 3, port1 = rid 0.
  - New rr = 1.
- **Partial and empty grants.**
  - Only req2 valid: `o_port_v`=2'b01 with rid 2.
  - No requester valid: `o_port_v`=0 and rr is unchanged.
- **Reset mid-batch.** Assert reset with a valid batch pending.
  - Next cycle: `o_port_v`=0 and rr=0.
  - While reset is low: `i_req_r`=0 even with all requesters valid.
- **Discard (`L1_RD_SCHED_DISCARD_EN`).** `i_l1_end[6]`=1, requesters with sids 5, 6, 7.
  - req1 is accepted with `o_discard`=4'b0010.
  - Ports carry sids 5 and 7 (rid 0 and rid 2).
  - With the macro undefined: ports carry sids 5 and 6, and `o_discard`=0.
